// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix scanner.
// FSM states, matrix geometry, PWM depth and a one-hot helper.
package led_scan_pkg;

  localparam int N_ROWS    = 8;
  localparam int N_COLS    = 8;
  localparam int PWM_STEPS = 16;
  localparam int LEVEL_W   = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_BLANK,
    ST_DISPLAY
  } state_t;

  function automatic logic [7:0] onehot8(
    input logic [2:0] i
  );
    onehot8 = 8'b1 << i;
  endfunction

endpackage

// File: rtl/led_line_fetch.sv
// Fetches one matrix row (8 levels) from the frame RAM into a shadow line.
// Ports: launch/row start a fetch; addr_*/rd_active drive RAM; done/shadow out.
module led_line_fetch
  import led_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        launch,
  input  logic [2:0]  row,
  input  logic        bus_busy,
  input  logic [3:0]  led_data,
  output logic [7:0]  addr_row,
  output logic [7:0]  addr_col,
  output logic        rd_active,
  output logic        done,
  output logic [31:0] shadow
);

  logic        r_active;
  logic [2:0]  r_col;
  logic [2:0]  r_row;
  logic        r_cap;
  logic [2:0]  r_cap_col;
  logic        r_done;
  logic [31:0] r_shadow;
  logic        w_issue;

  // A writer owning the bus simply stalls the current column.
  assign w_issue   = r_active & ~bus_busy;
  assign rd_active = w_issue;
  assign addr_row  = w_issue ? onehot8(r_row) : 8'h00;
  assign addr_col  = w_issue ? onehot8(r_col) : 8'h00;
  assign done      = r_done;
  assign shadow    = r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_col     <= 3'd0;
      r_row     <= 3'd0;
      r_cap     <= 1'b0;
      r_cap_col <= 3'd0;
      r_done    <= 1'b0;
      r_shadow  <= '0;
    end else begin
      // RAM data is valid one cycle after a real issue only.
      r_cap <= w_issue;
      if (w_issue)
        r_cap_col <= r_col;
      if (r_cap)
        r_shadow[{r_cap_col, 2'b00} +: LEVEL_W] <= led_data;
      if (launch) begin
        r_active <= 1'b1;
        r_col    <= 3'd0;
        r_row    <= row;
        r_done   <= 1'b0;
      end else begin
        if (w_issue) begin
          if (r_col == 3'd7)
            r_active <= 1'b0;
          r_col <= r_col + 3'd1;
        end
        if (r_cap && r_cap_col == 3'd7)
          r_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scan_pwm.sv
// 8x8 LED scanner: row FSM with blanking, PWM column drive, line prefetch.
// Ports: RAM read side (bus_busy, led_data, addr_*, rd_active); row_sel/col_on/frame_start.
module led_scan_pwm
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_busy,
  input  logic [3:0] led_data,
  output logic [7:0] addr_row,
  output logic [7:0] addr_col,
  output logic       rd_active,
  output logic [7:0] row_sel,
  output logic [7:0] col_on,
  output logic       frame_start
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(DEAD_CYCLES);

  state_t          r_state;
  state_t          w_nstate;
  logic [DW-1:0]   r_div;
  logic [3:0]      r_p;
  logic [TW-1:0]   r_dead;
  logic [2:0]      r_cur;
  logic [2:0]      r_frow;
  logic            r_kick;
  logic            r_frame;
  logic [31:0]     r_level;

  logic            w_done;
  logic [31:0]     w_shadow;
  logic            w_first;
  logic            w_launch;
  logic [2:0]      w_row;
  logic            w_dead_end;
  logic            w_slot_end;
  logic            w_xfer;
  logic            w_disp_end;

  // Counters are cleared on DISPLAY entry, so zero marks its first cycle.
  assign w_first    = (r_state == ST_DISPLAY) && (r_div == '0) && (r_p == 4'd0);
  assign w_launch   = ((r_state == ST_INIT) && r_kick) || w_first;
  assign w_row      = (r_state == ST_DISPLAY) ? r_cur + 3'd1 : 3'd0;
  assign w_dead_end = (r_dead == TW'(DEAD_CYCLES - 1));
  assign w_slot_end = (r_div == DW'(CLK_DIV - 1));
  assign w_xfer     = (r_state == ST_BLANK) && w_dead_end && w_done;
  assign w_disp_end = (r_state == ST_DISPLAY) && w_slot_end && (r_p == 4'd15);

  led_line_fetch u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch    (w_launch),
    .row       (w_row),
    .bus_busy  (bus_busy),
    .led_data  (led_data),
    .addr_row  (addr_row),
    .addr_col  (addr_col),
    .rd_active (rd_active),
    .done      (w_done),
    .shadow    (w_shadow)
  );

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_INIT:    if (w_done) w_nstate = ST_BLANK;
      ST_BLANK:   if (w_xfer) w_nstate = ST_DISPLAY;
      ST_DISPLAY: if (w_disp_end) w_nstate = ST_BLANK;
      default:    w_nstate = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_div   <= '0;
      r_p     <= 4'd0;
      r_dead  <= '0;
      r_cur   <= 3'd0;
      r_frow  <= 3'd0;
      r_kick  <= 1'b1;
      r_frame <= 1'b0;
      r_level <= '0;
    end else begin
      r_state <= w_nstate;
      r_frame <= w_xfer && (r_frow == 3'd0);
      if (w_launch) begin
        r_kick <= 1'b0;
        r_frow <= w_row;
      end
      if (w_xfer) begin
        r_level <= w_shadow;
        r_cur   <= r_frow;
      end
      // Dead counter parks on its last value while the fetch is late.
      if (r_state == ST_BLANK) begin
        if (!w_dead_end)
          r_dead <= r_dead + 1'b1;
      end else begin
        r_dead <= '0;
      end
      if (r_state == ST_DISPLAY) begin
        if (w_slot_end) begin
          r_div <= '0;
          r_p   <= r_p + 4'd1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else begin
        r_div <= '0;
        r_p   <= 4'd0;
      end
    end
  end

  always_comb begin
    row_sel = 8'h00;
    col_on  = 8'h00;
    if (r_state == ST_DISPLAY) begin
      row_sel = onehot8(r_cur);
      for (int c = 0; c < N_COLS; c++)
        col_on[c] = r_p < r_level[c*LEVEL_W +: LEVEL_W];
    end
  end

  assign frame_start = r_frame;

endmodule

// File: tb/tb_led_scan_pwm.sv
// Scoreboard bench for led_scan_pwm: expected rows queued, monitor checks each row.
// Covers reset, PWM duty, row stepping, busy stalls and async reset mid-row.
module tb_led_scan_pwm;

  localparam int CLK_DIV = 16;
  localparam int DEAD    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_busy = 1'b0;
  logic [3:0] led_data = 4'd0;
  logic [7:0] addr_row, addr_col, row_sel, col_on;
  logic       rd_active, frame_start;

  led_scan_pwm #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_busy    (bus_busy),
    .led_data    (led_data),
    .addr_row    (addr_row),
    .addr_col    (addr_col),
    .rd_active   (rd_active),
    .row_sel     (row_sel),
    .col_on      (col_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [8][8];
  int tests = 0;
  int fails = 0;
  int nprint = 0;

  function automatic int oh2i(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  // RAM model: one-cycle latency, garbage when no read was issued.
  always @(posedge clk) begin
    if (rd_active)
      led_data <= mem[oh2i(addr_row)][oh2i(addr_col)];
    else
      led_data <= 4'($urandom);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (nprint < 40)
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
      nprint++;
    end
  endtask

  typedef struct {
    logic [7:0]      sel;
    int              gap;
    int              len;
    logic [7:0][8:0] cnt;
    int              fs;
  } exp_t;

  exp_t q[$];

  task automatic push_row(input int r, input int gap);
    exp_t e;
    e.sel = 8'(1 << r);
    e.gap = gap;
    e.len = 16 * CLK_DIV;
    for (int c = 0; c < 8; c++)
      e.cnt[c] = 9'(int'(mem[r][c]) * CLK_DIV);
    e.fs = (r == 0) ? 1 : 0;
    q.push_back(e);
  endtask

  // Monitor: measures each DISPLAY row and the blank gap before it.
  logic       m_in = 1'b0;
  int         m_len = 0;
  int         m_gap = 0;
  int         m_fs = 0;
  int         m_cnt [8];
  logic [7:0] m_sel = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in  = 1'b0;
      m_gap = 0;
      m_fs  = 0;
    end else begin
      check("rd_bus",
        ((bus_busy && rd_active) ||
         (rd_active ? !($onehot(addr_row) && $onehot(addr_col))
                    : (addr_row != 8'h00 || addr_col != 8'h00))) ? 1 : 0, 0);
      m_fs += int'(frame_start);
      if (row_sel != 8'h00) begin
        if (!m_in) begin
          m_in  = 1'b1;
          m_len = 0;
          m_sel = row_sel;
          for (int c = 0; c < 8; c++) m_cnt[c] = 0;
        end
        check("row_sel_stable", int'(row_sel), int'(m_sel));
        m_len++;
        for (int c = 0; c < 8; c++)
          if (col_on[c]) m_cnt[c]++;
      end else begin
        if (col_on != 8'h00)
          check("col_on_blank", int'(col_on), 0);
        if (m_in) begin
          exp_t e;
          m_in = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_row", int'(m_sel), 0);
          end else begin
            e = q.pop_front();
            check("row_sel", int'(m_sel), int'(e.sel));
            check("gap", m_gap, e.gap);
            check("disp_len", m_len, e.len);
            for (int c = 0; c < 8; c++)
              check($sformatf("col%0d_on", c), m_cnt[c], int'(e.cnt[c]));
            check("frame_start", m_fs, e.fs);
          end
          m_gap = 0;
          m_fs  = 0;
        end
        m_gap++;
      end
    end
  end

  task automatic release_rst();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", int'(ok), 1);
  endtask

  task automatic wait_row(input logic [7:0] s, input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (row_sel == s) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_row_timeout", int'(ok), 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_row_sel"}, int'(row_sel), 0);
    check({tag, "_col_on"}, int'(col_on), 0);
    check({tag, "_addr_row"}, int'(addr_row), 0);
    check({tag, "_addr_col"}, int'(addr_col), 0);
    check({tag, "_rd_active"}, int'(rd_active), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    logic ok;
    // Phase 1: all levels 8.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 4'd8;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    push_row(0, 14);
    push_row(1, DEAD);
    release_rst();
    drain(2000);

    // Phase 2: level 15 everywhere, row 3 ramps 0..7; one full frame.
    rst_n = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = (r == 3) ? 4'(c) : 4'd15;
    for (int r = 0; r < 8; r++)
      push_row(r, (r == 0) ? 14 : DEAD);
    push_row(0, DEAD);
    repeat (2) @(posedge clk);
    release_rst();
    drain(4000);

    // Phase 3: distinct levels; short busy during column 4 issue.
    rst_n = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 4'((r * 3 + c * 2) & 15);
    push_row(0, 14);
    push_row(1, DEAD);
    push_row(2, 55);
    push_row(3, DEAD);
    push_row(4, DEAD);
    repeat (2) @(posedge clk);
    release_rst();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_active && addr_col == 8'h08 && row_sel == 8'h01) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_col3_timeout", int'(ok), 1);
    @(posedge clk);
    #1 bus_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_busy = 1'b0;
    @(negedge clk);
    check("col4_reissue", int'({rd_active, addr_col}), int'({1'b1, 8'h10}));

    // Phase 4: long busy from second cycle of row 1 past its end.
    wait_row(8'h02, 1000);
    @(posedge clk);
    #1 bus_busy = 1'b1;
    repeat (300) @(posedge clk);
    #1 bus_busy = 1'b0;
    drain(2000);

    // Phase 5: async reset in the middle of row 5.
    wait_row(8'h20, 1000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    repeat (4) @(posedge clk);
    push_row(0, 14);
    push_row(1, DEAD);
    release_rst();
    drain(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
